// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: execute-stage aluop
// encodings (identical to the decode-stage values), FSM states and step modes.
package muldiv_ctrl_pkg;

  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_t;

  // Ops that start an iterative operation.
  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == MULT_OP) || (op == DIV_OP);
  endfunction

  // Ops that must wait while an operation is in flight.
  function automatic logic is_md_user(input logic [5:0] op);
    return (op == MULT_OP) || (op == DIV_OP) || (op == MFHI_OP) || (op == MFLO_OP);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_md_step.sv
// One combinational iteration of the shared mul/div datapath.
// mul: acc = {partial product, remaining multiplier bits}; shift-add, LSB first.
// div: acc = {partial remainder, remaining dividend / quotient bits}; restoring step.
module muldiv_ctrl_md_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_mode_t             i_mode,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Single shift-add or shift-subtract step selected by mode.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_operand};
    o_acc    = i_acc;
    if (i_mode == MD_MUL) begin
      // Carry out of the add lands in the top bit as the accumulator shifts right.
      if (i_acc[0]) o_acc = {w_sum, i_acc[WIDTH-1:1]};
      else          o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
    end else begin
      // w_diff[WIDTH] set means the trial subtract borrowed: restore, quotient bit 0.
      if (!w_diff[WIDTH]) o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      else                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside the execute-stage ALU. Owns HI/LO, runs
// MULT(U)/DIV(U) over ITERS cycles on a shared step datapath, stalls execute
// while a later mul/div or HI/LO read has to wait.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = WIDTH  // must equal WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [5:0]       i_aluop,
  input  logic             i_issue,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(ITERS - 1);

  md_state_t          r_state, w_state_nxt;
  logic [CW-1:0]      r_count;
  md_mode_t           r_mode;
  logic               r_signed, r_sign_a, r_sign_b, r_dz;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_div_zero;

  logic               w_accept, w_is_div, w_div_zero_op;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_accept      = (r_state == IDLE) && i_issue && is_muldiv(i_aluop);
  assign w_is_div      = (i_aluop == DIV_OP);
  assign w_div_zero_op = w_is_div && (i_op_b == '0);
  assign w_mag_a       = (i_is_signed && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
  assign w_mag_b       = (i_is_signed && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;
  assign o_div_zero    = r_div_zero;

  muldiv_ctrl_md_step #(
    .WIDTH(WIDTH)
  ) u_md_step (
    .i_mode   (r_mode),
    .i_acc    (r_acc),
    .i_operand(r_operand),
    .o_acc    (w_step_acc)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and control/output decode.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != IDLE);
    o_done      = 1'b0;
    o_hi        = r_hi;
    o_lo        = r_lo;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_div_zero_op ? FIX : RUN;
      RUN:  if (r_count == LastCnt) w_state_nxt = FIX;
      FIX: begin
        // The new result is visible on HI/LO in the done cycle itself.
        w_state_nxt = IDLE;
        o_done      = 1'b1;
        o_hi        = w_fix_hi;
        o_lo        = w_fix_lo;
      end
      default: w_state_nxt = IDLE;
    endcase
    o_stall   = i_issue && o_busy && is_md_user(i_aluop);
    o_rd_data = (i_aluop == MFHI_OP) ? o_hi : (i_aluop == MFLO_OP) ? o_lo : '0;
  end

  // Sign fixup of the unsigned magnitude result.
  always_comb begin
    w_prod = (r_signed && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
    w_quo  = (r_signed && (r_sign_a ^ r_sign_b)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = (r_signed && r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (r_dz) begin
      w_fix_hi = r_acc[WIDTH-1:0];  // raw dividend kept for the divide-by-zero case
      w_fix_lo = '1;
    end else if (r_mode == MD_MUL) begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  // Operand latch, iteration, and HI/LO write-back.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count    <= '0;
      r_mode     <= MD_MUL;
      r_signed   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_dz       <= 1'b0;
      r_acc      <= '0;
      r_operand  <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_count    <= '0;
      r_mode     <= w_is_div ? MD_DIV : MD_MUL;
      r_signed   <= i_is_signed;
      r_sign_a   <= i_op_a[WIDTH-1];
      r_sign_b   <= i_op_b[WIDTH-1];
      r_dz       <= w_div_zero_op;
      r_div_zero <= w_div_zero_op;
      if (!w_is_div)         r_acc <= {{WIDTH{1'b0}}, w_mag_b};
      else if (w_div_zero_op) r_acc <= {{WIDTH{1'b0}}, i_op_a};
      else                   r_acc <= {{WIDTH{1'b0}}, w_mag_a};
      r_operand  <= w_is_div ? w_mag_b : w_mag_a;
    end else if (r_state == RUN) begin
      r_acc   <= w_step_acc;
      r_count <= r_count + CW'(1);
    end else if (r_state == FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases with literal expectations plus a long
// random run, all checked every cycle against a cycle-count reference model.
module tb_muldiv_ctrl;

  localparam int ITERS = 32;
  localparam logic [5:0] L_MULT = 6'b000010;
  localparam logic [5:0] L_DIV  = 6'b000011;
  localparam logic [5:0] L_MFHI = 6'b000100;
  localparam logic [5:0] L_MFLO = 6'b000101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  aluop = 6'd0;
  logic        issue = 1'b0;
  logic        sg = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] o_hi, o_lo, o_rd_data;
  logic        o_busy, o_stall, o_done, o_div_zero;

  int total = 0;
  int bad = 0;

  muldiv_ctrl dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_aluop    (aluop),
    .i_issue    (issue),
    .i_is_signed(sg),
    .i_op_a     (a),
    .i_op_b     (b),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_rd_data  (o_rd_data),
    .o_busy     (o_busy),
    .o_stall    (o_stall),
    .o_done     (o_done),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one mul/div, straight from the arithmetic.
  function automatic void calc(input logic [5:0] op, input logic s, input logic [31:0] x,
                               input logic [31:0] y, output logic [31:0] rh,
                               output logic [31:0] rl, output logic z);
    logic [63:0] p;
    longint q, r;
    z = 1'b0;
    if (op == L_MULT) begin
      if (s) p = 64'(longint'($signed(x)) * longint'($signed(y)));
      else   p = {32'b0, x} * {32'b0, y};
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == 32'd0) begin
      rh = x;
      rl = 32'hFFFF_FFFF;
      z  = 1'b1;
    end else if (s) begin
      q  = longint'($signed(x)) / longint'($signed(y));
      r  = longint'($signed(x)) % longint'($signed(y));
      rh = r[31:0];
      rl = q[31:0];
    end else begin
      rl = x / y;
      rh = x % y;
    end
  endfunction

  // Reference model: an accepted op keeps the unit busy for a fixed number of
  // cycles; the result shows in the last of them and is kept afterwards.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;
  logic        m_dz = 1'b0;
  logic        zero_q;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_hi = 0;
      m_lo = 0;
      m_dz = 1'b0;
    end else begin
      if (m_left == 1) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
      if (m_left > 0) m_left--;
      else if (issue && (aluop == L_MULT || aluop == L_DIV)) begin
        calc(aluop, sg, a, b, m_rhi, m_rlo, zero_q);
        m_dz   = zero_q;
        m_left = zero_q ? 1 : ITERS + 1;
      end
    end
  end

  logic        e_busy, e_done, e_stall, e_dz;
  logic [31:0] e_hi, e_lo, e_rd;

  // Compare every output against the model away from the clock edge.
  always @(negedge clk) begin
    e_busy  = !rst && (m_left > 0);
    e_done  = !rst && (m_left == 1);
    e_dz    = !rst && m_dz;
    e_hi    = rst ? 32'd0 : (e_done ? m_rhi : m_hi);
    e_lo    = rst ? 32'd0 : (e_done ? m_rlo : m_lo);
    e_stall = issue && e_busy &&
              (aluop == L_MULT || aluop == L_DIV || aluop == L_MFHI || aluop == L_MFLO);
    e_rd    = (aluop == L_MFHI) ? e_hi : (aluop == L_MFLO) ? e_lo : 32'd0;
    check("busy", 32'(o_busy), 32'(e_busy));
    check("done", 32'(o_done), 32'(e_done));
    check("stall", 32'(o_stall), 32'(e_stall));
    check("div_zero", 32'(o_div_zero), 32'(e_dz));
    check("hi", o_hi, e_hi);
    check("lo", o_lo, e_lo);
    check("rd_data", o_rd_data, e_rd);
  end

  // Issue one op from an idle unit; lat counts cycles with the issue cycle as 1.
  task automatic do_op(input logic [5:0] op, input logic s, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] rh, output logic [31:0] rl,
                       output int lat, output int bcnt);
    aluop = op; sg = s; a = x; b = y; issue = 1'b1;
    lat = 1; bcnt = 0; rh = 32'd0; rl = 32'd0;
    @(posedge clk); #1;
    issue = 1'b0; aluop = 6'd0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (o_busy) bcnt++;
      if (o_done) begin
        rh = o_hi;
        rl = o_lo;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl;
    int lat, bc, n, dn, stalls;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_hi", o_hi, 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);

    do_op(L_MULT, 1'b0, 32'd7, 32'd6, rh, rl, lat, bc);
    check("multu_lat", lat, 32'd34);
    check("multu_busy_cycles", bc, 32'd33);
    check("multu_hi", rh, 32'd0);
    check("multu_lo", rl, 32'd42);
    check("multu_idle_after", 32'(o_busy), 32'd0);

    do_op(L_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, rh, rl, lat, bc);
    check("mult_neg_lat", lat, 32'd34);
    check("mult_neg_hi", rh, 32'hFFFF_FFFF);
    check("mult_neg_lo", rl, 32'hFFFF_FFF1);
    do_op(L_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, rh, rl, lat, bc);
    check("mult_min_hi", rh, 32'h4000_0000);
    check("mult_min_lo", rl, 32'd0);

    do_op(L_DIV, 1'b0, 32'd100, 32'd7, rh, rl, lat, bc);
    check("divu_lat", lat, 32'd34);
    check("divu_lo", rl, 32'd14);
    check("divu_hi", rh, 32'd2);
    do_op(L_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, rh, rl, lat, bc);
    check("div_neg_lo", rl, 32'hFFFF_FFFD);
    check("div_neg_hi", rh, 32'hFFFF_FFFF);
    do_op(L_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, lat, bc);
    check("div_ovf_lo", rl, 32'h8000_0000);
    check("div_ovf_hi", rh, 32'd0);

    do_op(L_DIV, 1'b1, 32'd5, 32'd0, rh, rl, lat, bc);
    check("div0_lat", lat, 32'd2);
    check("div0_hi", rh, 32'd5);
    check("div0_lo", rl, 32'hFFFF_FFFF);
    check("div0_flag", 32'(o_div_zero), 32'd1);
    do_op(L_MULT, 1'b0, 32'd1, 32'd1, rh, rl, lat, bc);
    check("div0_clear_lo", rl, 32'd1);
    check("div0_cleared", 32'(o_div_zero), 32'd0);

    // MFHI three cycles after a MULT: held by stall until busy drops.
    aluop = L_MULT; sg = 1'b0; a = 32'h0001_0000; b = 32'h0003_0000; issue = 1'b1;
    @(posedge clk); #1 issue = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 aluop = L_MFHI; issue = 1'b1;
    stalls = 0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (!o_stall) break;
      stalls++;
    end
    check("mfhi_stall_cycles", stalls, 32'd31);
    check("mfhi_rd_data", o_rd_data, 32'd3);
    @(posedge clk); #1 issue = 1'b0;

    // Back-to-back MULTU: the second starts only once the first is done.
    aluop = L_MULT; sg = 1'b0; a = 32'd3; b = 32'd4; issue = 1'b1;
    @(posedge clk); #1 a = 32'd5; b = 32'd5;
    n = 1; dn = 0;
    while (dn < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (o_done) begin
        dn++;
        if (dn == 1) begin
          check("b2b_first_cycle", n, 32'd34);
          check("b2b_first_lo", o_lo, 32'd12);
        end else begin
          check("b2b_second_cycle", n, 32'd68);
          check("b2b_second_lo", o_lo, 32'd25);
        end
      end
      if (issue && !o_stall) begin
        @(posedge clk); #1 issue = 1'b0;
      end
    end
    check("b2b_dones", dn, 32'd2);
    @(posedge clk); #1;

    // Reset in the middle of RUN discards the operation and HI/LO.
    do_op(L_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, rh, rl, lat, bc);
    check("pre_reset_hi", rh, 32'd1);
    aluop = L_MULT; sg = 1'b0; a = 32'd9; b = 32'd9; issue = 1'b1;
    @(posedge clk); #1 issue = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_hi", o_hi, 32'd0);
    check("abort_lo", o_lo, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_op(L_MULT, 1'b0, 32'd2, 32'd3, rh, rl, lat, bc);
    check("post_reset_lat", lat, 32'd34);
    check("post_reset_lo", rl, 32'd6);

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 799) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: aluop = L_MULT;
        3, 4, 5: aluop = L_DIV;
        6:       aluop = L_MFHI;
        7:       aluop = L_MFLO;
        8:       aluop = 6'b000000;
        default: aluop = 6'b100001;
      endcase
      issue = ($urandom_range(0, 3) != 0);
      sg    = 1'($urandom_range(0, 1));
      a     = rnd_val();
      b     = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd_val();
      @(posedge clk); #1;
    end
    rst = 1'b0;
    issue = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
